// File: rtl/pga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pga_pkg
// Description : Shared types, constants and packet builder for the PGA
//               serial controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pga_pkg;

    localparam int PKT_W = 8;

    localparam logic TYPE_VOS  = 1'b0;
    localparam logic TYPE_GAIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        END   = 2'd2
    } pga_state_e;

    // Offset packets end in 0 and gain packets end in 1; the PGA uses bit0 as the type tag.
    function automatic logic [PKT_W-1:0] build_packet(
        input logic       pkt_type,
        input logic       shdn,
        input logic       meas,
        input logic [4:0] offset,
        input logic [3:0] gain
    );
        logic [PKT_W-1:0] pkt;
        if (pkt_type == TYPE_GAIN) begin
            pkt = {shdn, meas, 1'b0, gain, 1'b1};
        end else begin
            pkt = {shdn, meas, offset, 1'b0};
        end
        return pkt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pga_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : pga_clk_div
// Description : Free-running CLK_DIV counter producing a one-cycle tick,
//               with synchronous clear to re-align on a new command.
// Revision    : 1.0 - initial release
// ============================================================================
module pga_clk_div #(
    parameter int CLK_DIV = 5
) (
    input  logic clk50,
    input  logic wb_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk50 or posedge wb_rst) begin
        if (wb_rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/pga_multi_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pga_multi_ctrl
// Description : Serial write controller for NUM_CH PGAs on a shared data
//               line with per-channel gated SCLK. Optional per-channel
//               shadow readback enabled by `define PGA_SHADOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pga_multi_ctrl
    import pga_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 5,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk50,
    input  logic              wb_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic              cmd_gain,
    input  logic [4:0]        cmd_offset,
    input  logic [3:0]        cmd_gainval,
    input  logic              cmd_shdn,
    input  logic              cmd_meas,
    output logic              done,
    output logic              err,
    output logic              pga_dat,
    output logic [NUM_CH-1:0] pga_clk,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [4:0]        rd_offset,
    output logic [3:0]        rd_gain
);

    localparam logic [CH_W:0] c_num_ch   = (CH_W + 1)'(NUM_CH);
    localparam logic [2:0]    c_last_idx = 3'(PKT_W - 1);

    pga_state_e        r_state;
    logic              r_ready;
    logic              r_err;
    logic              r_dat;
    logic              r_phase;
    logic [2:0]        r_idx;
    logic [CH_W-1:0]   r_ch;
    logic [NUM_CH-1:0] r_pga_clk;
    logic              r_type;
    logic              r_shdn;
    logic              r_meas;
    logic [4:0]        r_off;
    logic [3:0]        r_gain;

    logic              w_tick;
    logic              w_accept;
    logic              w_ch_ok;
    logic [PKT_W-1:0]  w_pkt;
    logic [NUM_CH-1:0] w_ch_mask;

    assign w_accept = cmd_valid && r_ready;
    assign w_ch_ok  = ({1'b0, cmd_ch} < c_num_ch);
    assign w_pkt    = build_packet(r_type, r_shdn, r_meas, r_off, r_gain);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_mask
            assign w_ch_mask[gi] = (r_ch == CH_W'(gi));
        end
    endgenerate

    pga_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk50  (clk50),
        .wb_rst (wb_rst),
        .i_clr  (w_accept),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk50 or posedge wb_rst) begin
        if (wb_rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= 1'b0;
            r_phase   <= 1'b0;
            r_idx     <= '0;
            r_ch      <= '0;
            r_pga_clk <= '0;
            r_type    <= TYPE_VOS;
            r_shdn    <= 1'b0;
            r_meas    <= 1'b0;
            r_off     <= '0;
            r_gain    <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready   <= 1'b1;
                    r_pga_clk <= '0;
                    if (w_accept) begin
                        if (w_ch_ok) begin
                            r_state <= SHIFT;
                            r_ready <= 1'b0;
                            r_ch    <= cmd_ch;
                            r_type  <= cmd_gain;
                            r_shdn  <= cmd_shdn;
                            r_meas  <= cmd_meas;
                            r_off   <= cmd_offset;
                            r_gain  <= cmd_gainval;
                            r_idx   <= '0;
                            r_phase <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Data moves on the falling phase so it is settled a full half-period around each rise.
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_dat     <= w_pkt[r_idx];
                            r_pga_clk <= '0;
                            r_phase   <= 1'b1;
                        end else begin
                            r_pga_clk <= w_ch_mask;
                            r_phase   <= 1'b0;
                            if (r_idx == c_last_idx) begin
                                r_state <= END;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                end
                END: begin
                    if (w_tick) begin
                        r_pga_clk <= '0;
                        r_dat     <= 1'b0;
                        r_ready   <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign err       = r_err;
    assign pga_dat   = r_dat;
    assign pga_clk   = r_pga_clk;
    assign done      = (r_state == END) && w_tick;

`ifdef PGA_SHADOW_EN
    logic [4:0] r_sh_off  [NUM_CH];
    logic [3:0] r_sh_gain [NUM_CH];
    logic       w_rd_ok;

    always_ff @(posedge clk50 or posedge wb_rst) begin
        if (wb_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_sh_off[i]  <= '0;
                r_sh_gain[i] <= '0;
            end
        end else if (done) begin
            if (r_type == TYPE_GAIN) begin
                r_sh_gain[r_ch] <= r_gain;
            end else begin
                r_sh_off[r_ch] <= r_off;
            end
        end
    end

    assign w_rd_ok   = ({1'b0, rd_ch} < c_num_ch);
    assign rd_offset = w_rd_ok ? r_sh_off[rd_ch]  : 5'd0;
    assign rd_gain   = w_rd_ok ? r_sh_gain[rd_ch] : 4'd0;
`else
    logic w_rd_unused;

    assign w_rd_unused = ^rd_ch;
    assign rd_offset   = 5'd0;
    assign rd_gain     = 4'd0;
`endif

endmodule
`default_nettype wire

// File: doc/pga_multi_ctrl.md
Name: pga_multi_ctrl

Overview:
Parametrised serial controller for a bank of NUM_CH programmable-gain amplifiers sharing one data line, with one gated serial clock per channel.
- Accepts offset or gain write commands through a valid/ready handshake.
- Builds the 8-bit PGA packet, shifts it LSB-first to the addressed channel, then pulses done.
- Sits between the Wishbone register file and the PGA pins; fully synchronous to clk50 (divider-derived clock enables, no generated clock domain).

Parameters:
NUM_CH, 4, number of PGA channels (1..16).
CLK_DIV, 5, clk50 cycles per SCLK half-period (>=2); default gives 5 MHz SCLK.
CH_W, $clog2(NUM_CH) (min 1), channel index width (derived, not overridden).

Ports:
clk50  in  1  system clock.
wb_rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  command request.
cmd_ready  out  1  block can accept a command (IDLE only).
cmd_ch  in  CH_W  target channel.
cmd_gain  in  1  1 = gain write, 0 = offset write.
cmd_offset  in  5  offset code.
cmd_gainval  in  4  gain code.
cmd_shdn  in  1  shutdown bit.
cmd_meas  in  1  measure bit.
done  out  1  one-cycle pulse, packet finished.
err  out  1  one-cycle pulse, command dropped (cmd_ch >= NUM_CH).
pga_dat  out  1  shared serial data.
pga_clk  out  NUM_CH  per-channel serial clock; only the addressed bit toggles.
rd_ch  in  CH_W  shadow read select.
rd_offset  out  5  shadow offset of rd_ch.
rd_gain  out  4  shadow gain of rd_ch.

Behaviour:
- Reset, async, all outputs: cmd_ready=0, done=0, err=0, pga_dat=0, pga_clk=0, state=IDLE. cmd_ready rises the first cycle after deassertion.
- Accept: cmd_valid && cmd_ready on a clk50 edge.
  - Fields are latched; the divider counter clears to 0.
  - Packet: offset = {shdn, meas, offset[4:0], 0}; gain = {shdn, meas, 0, gain[3:0], 1}.
  - Transmitted bit0 first.
- Tick: one-cycle strobe when div_cnt == CLK_DIV-1; div_cnt then wraps to 0.
- States:
  - IDLE: cmd_ready=1, pga_clk all 0. Accept with a valid channel goes to SHIFT. Accept with an invalid channel pulses err next cycle and stays IDLE (no SCLK, no done).
  - SHIFT: uses a 3-bit bit index and a phase bit.
    - Phase-0 tick: pga_dat <= packet[idx]; pga_clk[ch] <= 0.
    - Phase-1 tick: pga_clk[ch] <= 1; the PGA samples on this rising edge.
    - After the phase-1 tick of idx=7, go to END.
  - END: next tick drives pga_clk[ch] <= 0, pga_dat <= 0, done=1 for one cycle, then IDLE.
- Latency: done asserts (2*8+1)*CLK_DIV cycles after acceptance; 85 cycles at default. cmd_ready returns the cycle after done.
- Data stability: pga_dat is stable CLK_DIV cycles before and after every rising edge of pga_clk[ch].
- Channel isolation: non-addressed pga_clk bits stay 0 throughout.
- cmd_* changes after acceptance are ignored. cmd_valid held through busy is not accepted until IDLE.
- Back-to-back: a command may be accepted in the first IDLE cycle. Minimum gap between transactions is 1 cycle plus CLK_DIV cycles to the first tick.
- Reset mid-transfer: immediate abort, outputs to reset values, no done, shadow registers cleared.
- Shadow update: on done, the offset or gain field of that channel is written. Shadow regs reset to 0.

Optional Feature:
PGA_SHADOW_EN.
- Defined: per-channel shadow registers implemented. rd_offset/rd_gain return combinationally the last completed write for rd_ch; rd_ch >= NUM_CH reads 0.
- Undefined: no shadow storage; rd_offset and rd_gain tied to 0, rd_ch ignored. Ports remain for a stable interface.

Decomposition:
- Package pga_pkg:
  - state enum (IDLE, SHIFT, END);
  - PKT_W=8 constant;
  - packet-type bit constants (TYPE_VOS=0, TYPE_GAIN=1);
  - a packet-build function taking type, shdn, meas, offset, gain.
- One sub-module, pga_clk_div: parametrised CLK_DIV counter with synchronous clear input and tick output. The shift FSM stays in the top level.

Test Plan:
- Reset release then offset write ch2, offset=5'b10110, shdn=0, meas=1:
  - pga_dat sampled on pga_clk[2] rises = 0,0,1,1,0,1,1,0 (LSB first);
  - pga_clk[0,1,3] stay 0;
  - done at cycle 85 after accept.
- Gain write ch0, gain=4'b1001, shdn=1, meas=0 -> sampled bits 1,1,0,0,1,0,0,1; err=0.
- cmd_ch=4 with NUM_CH=4 -> err one cycle after accept; no pga_clk activity; no done; cmd_ready stays 1.
- Assert wb_rst at the 4th pga_clk rise -> all outputs 0 within the same cycle; no done. A fresh command after release completes normally.
- Two back-to-back commands, cmd_valid held high -> second accepted the cycle after the first done; total 2x85+1 cycles.
- PGA_SHADOW_EN defined: write ch1 offset 7 then gain 3 -> rd_ch=1 gives rd_offset=7, rd_gain=3, and rd_ch=0 gives 0. Undefined: both read 0.
